// File: rtl/mem_access_initiator_pkg.sv
// Shared types for the MEM-stage data-memory initiator: access size codes, FSM states,
// the latched request record and small decode helpers.
`timescale 1ns/1ps
package mem_access_initiator_pkg;

    localparam logic [1:0] SIZE_NONE = 2'd0;
    localparam logic [1:0] SIZE_BYTE = 2'd1;
    localparam logic [1:0] SIZE_HALF = 2'd2;
    localparam logic [1:0] SIZE_WORD = 2'd3;

    // Widest byte address the latched request record can carry.
    localparam int unsigned MaxAddrWidth = 32;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StSplit,
        StResp
    } state_e;

    typedef struct packed {
        logic                    store;
        logic [1:0]              size;
        logic [MaxAddrWidth-1:0] addr;
        logic [31:0]             wdata;
    } mem_req_t;

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = ~addr_lo[0];
            SIZE_WORD: ok = (addr_lo == 2'b00);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] size_mask(input logic [1:0] size);
        logic [31:0] m;
        case (size)
            SIZE_BYTE: m = 32'h0000_00ff;
            SIZE_HALF: m = 32'h0000_ffff;
            SIZE_WORD: m = 32'hffff_ffff;
            default:   m = 32'h0000_0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_access_initiator.sv
// MEM-stage initiator for the byte-addressed data memory: one request at a time, aligned
// accesses in one memory cycle, misaligned ones split into sequential byte accesses.
`timescale 1ns/1ps
module mem_access_initiator
    import mem_access_initiator_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH       = 32,  // must not exceed MaxAddrWidth
    parameter bit          ALLOW_MISALIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [1:0]            req_size,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,

    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,

    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_data_in,
    output logic [1:0]            mem_write,
    output logic [1:0]            mem_read,
    input  logic [31:0]           mem_data_out
);

    state_e                  state_q;
    mem_req_t                req_q;
    logic [1:0]              cnt_q;
    logic                    aligned_in;
    logic                    split_last;
    logic [ADDR_WIDTH-1:0]   addr_q;

    assign aligned_in = is_aligned(req_size, req_addr[1:0]);
    assign addr_q     = req_q.addr[ADDR_WIDTH-1:0];
    assign split_last = (req_q.size == SIZE_HALF) ? (cnt_q == 2'd1) : (cnt_q == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            req_q      <= '0;
            cnt_q      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        req_q <= '{store: req_store,
                                   size:  req_size,
                                   addr:  MaxAddrWidth'(req_addr),
                                   wdata: req_wdata};
                        cnt_q      <= '0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b0;
                        if (req_size == SIZE_NONE || (!aligned_in && !ALLOW_MISALIGNED)) begin
                            // Rejected requests never touch memory.
                            state_q    <= StResp;
                            resp_err   <= 1'b1;
                            resp_valid <= 1'b1;
                        end else if (aligned_in) begin
                            state_q <= StAccess;
                        end else begin
                            state_q <= StSplit;
                        end
                    end
                end
                StAccess: begin
                    if (!req_q.store) begin
                        resp_rdata <= mem_data_out & size_mask(req_q.size);
                    end
                    state_q    <= StResp;
                    resp_valid <= 1'b1;
                end
                StSplit: begin
                    if (!req_q.store) begin
                        resp_rdata[{cnt_q, 3'b000} +: 8] <= mem_data_out[7:0];
                    end
                    cnt_q <= cnt_q + 2'd1;
                    if (split_last) begin
                        state_q    <= StResp;
                        resp_valid <= 1'b1;
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        state_q    <= StIdle;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Memory strobes come only from state and latched request, so they are quiet in idle/resp.
    always_comb begin
        mem_address = '0;
        mem_data_in = '0;
        mem_write   = SIZE_NONE;
        mem_read    = SIZE_NONE;
        unique case (state_q)
            StAccess: begin
                mem_address = addr_q;
                mem_data_in = req_q.wdata;
                if (req_q.store) begin
                    mem_write = req_q.size;
                end else begin
                    mem_read = req_q.size;
                end
            end
            StSplit: begin
                mem_address = addr_q + ADDR_WIDTH'(cnt_q);
                mem_data_in = {24'h0, req_q.wdata[{cnt_q, 3'b000} +: 8]};
                if (req_q.store) begin
                    mem_write = SIZE_BYTE;
                end else begin
                    mem_read = SIZE_BYTE;
                end
            end
            default: ;
        endcase
    end

endmodule
